// File: rtl/ad_cail_feeder_if.sv
// Bus interfaces of ad_cail_feeder: the AD7606 capture word stream (master = capture logic)
// and the burst link to data_cail (master = feeder).

interface ad_cail_feeder_ad_if;
  logic [15:0] ad_data;
  logic        ad_data_vld;
  logic        ad_frame_end;

  modport master (output ad_data, ad_data_vld, ad_frame_end);
  modport slave  (input  ad_data, ad_data_vld, ad_frame_end);
endinterface

interface ad_cail_feeder_cail_if #(parameter int LEN_W = 8);
  logic [15:0]      short_data;
  logic             cail_en;
  logic [LEN_W-1:0] data_len;
  logic             cail_done;

  modport master (output short_data, cail_en, data_len, input  cail_done);
  modport slave  (input  short_data, cail_en, data_len, output cail_done);
endinterface

// File: rtl/ad_cail_feeder.sv
// Ping-pong frame buffer between AD7606 capture and data_cail: each captured frame is
// replayed as one gap-free burst, with overrun detection and a saturating drop counter.

module ad_cail_feeder #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ad_cail_feeder_ad_if.slave    ad_i,
  ad_cail_feeder_cail_if.master cail_o,
  input  logic                  clr_ovf_i,
  output logic                  busy_o,
  output logic                  ovf_flag_o,
  output logic [LEN_W-1:0]      drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, WAIT_DONE} state_e;

  state_e                 state_q, state_d;
  logic [15:0]            mem_q [2*DEPTH];
  logic [1:0]             full_q, full_d, set_full, clr_full;
  logic [1:0][PW-1:0]     len_q, len_d;
  logic                   fill_bank_q, fill_bank_d;
  logic                   in_frame_q, in_frame_d;
  logic                   drop_q, drop_d;
  logic [PW-1:0]          wptr_q, wptr_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [15:0]            short_data_q, short_data_d;
  logic                   cail_en_q, cail_en_d;
  logic [LEN_W-1:0]       data_len_q, data_len_d;
  logic                   ovf_q, ovf_d;
  logic [LEN_W-1:0]       drop_cnt_q, drop_cnt_d;
  logic                   frame_drop, wr_en;

  // Banks are filled and drained in strict alternation, so the fill bank is decided
  // once per frame at its first word: if it is still occupied, the whole frame is dropped.
  always_comb begin
    frame_drop  = in_frame_q ? drop_q : full_q[fill_bank_q];
    wr_en       = ad_i.ad_data_vld && !frame_drop && (wptr_q != PW'(DEPTH));
    fill_bank_d = fill_bank_q;
    in_frame_d  = in_frame_q;
    drop_d      = drop_q;
    wptr_d      = wptr_q;
    len_d       = len_q;
    set_full    = '0;
    ovf_d       = ovf_q;
    drop_cnt_d  = drop_cnt_q;

    if (clr_ovf_i) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end

    if (ad_i.ad_data_vld) begin
      drop_d = frame_drop;
      if (!frame_drop && (wptr_q == PW'(DEPTH))) begin
        ovf_d = 1'b1;
      end
      if (ad_i.ad_frame_end) begin
        in_frame_d = 1'b0;
        drop_d     = 1'b0;
        wptr_d     = '0;
        if (frame_drop) begin
          ovf_d = 1'b1;
          if (drop_cnt_d != '1) begin
            drop_cnt_d = drop_cnt_d + 1'b1;
          end
        end else begin
          set_full[fill_bank_q] = 1'b1;
          len_d[fill_bank_q]    = (wptr_q == PW'(DEPTH)) ? wptr_q : wptr_q + 1'b1;
          fill_bank_d           = ~fill_bank_q;
        end
      end else begin
        in_frame_d = 1'b1;
        if (wptr_q != PW'(DEPTH)) begin
          wptr_d = wptr_q + 1'b1;
        end
      end
    end
  end

  // rptr runs one ahead of the word on short_data; the burst ends when it reaches len.
  always_comb begin
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    rptr_d       = rptr_q;
    short_data_d = short_data_q;
    cail_en_d    = 1'b0;
    data_len_d   = data_len_q;
    clr_full     = '0;

    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        data_len_d   = LEN_W'(len_q[rd_bank_q]);
        short_data_d = mem_q[{rd_bank_q, {AW{1'b0}}}];
        cail_en_d    = 1'b1;
        rptr_d       = PW'(1);
        state_d      = STREAM;
      end
      STREAM: begin
        if (rptr_q == len_q[rd_bank_q]) begin
          state_d = WAIT_DONE;
        end else begin
          short_data_d = mem_q[{rd_bank_q, rptr_q[AW-1:0]}];
          rptr_d       = rptr_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (cail_o.cail_done) begin
          clr_full[rd_bank_q] = 1'b1;
          rd_bank_d           = ~rd_bank_q;
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full_d = (full_q | set_full) & ~clr_full;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{fill_bank_q, wptr_q[AW-1:0]}] <= ad_i.ad_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      full_q       <= '0;
      len_q        <= '0;
      fill_bank_q  <= 1'b0;
      in_frame_q   <= 1'b0;
      drop_q       <= 1'b0;
      wptr_q       <= '0;
      rd_bank_q    <= 1'b0;
      rptr_q       <= '0;
      short_data_q <= '0;
      cail_en_q    <= 1'b0;
      data_len_q   <= '0;
      ovf_q        <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      len_q        <= len_d;
      fill_bank_q  <= fill_bank_d;
      in_frame_q   <= in_frame_d;
      drop_q       <= drop_d;
      wptr_q       <= wptr_d;
      rd_bank_q    <= rd_bank_d;
      rptr_q       <= rptr_d;
      short_data_q <= short_data_d;
      cail_en_q    <= cail_en_d;
      data_len_q   <= data_len_d;
      ovf_q        <= ovf_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign cail_o.short_data = short_data_q;
  assign cail_o.cail_en    = cail_en_q;
  assign cail_o.data_len   = data_len_q;
  assign busy_o            = (state_q != IDLE);
  assign ovf_flag_o        = ovf_q;
  assign drop_cnt_o        = drop_cnt_q;

endmodule

// File: doc/ad_cail_feeder.md
Name: ad_cail_feeder

Overview:
- Sits between the AD7606 capture logic and data_cail.
- Collects each conversion frame of 16-bit channel words into a ping-pong buffer.
- Replays each frame to data_cail as a contiguous burst: a one-cycle cail_en pulse with word 0, then one word per clock, plus data_len.
- Waits for data_cail to report completion before starting the next burst. Overruns are flagged and counted.

Parameters:
- DEPTH, 8, words per bank (maximum frame length); power of two, 2..64.
- LEN_W, 8, width of data_len and drop_cnt.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ad_data  in  16  channel word from AD7606 capture.
- ad_data_vld  in  1  ad_data valid, one word per high cycle.
- ad_frame_end  in  1  last word of frame; qualified by ad_data_vld.
- cail_done  in  1  one-cycle pulse from data_cail: burst fully processed.
- clr_ovf  in  1  clears ovf_flag and drop_cnt.
- short_data  out  16  word to data_cail.
- cail_en  out  1  one-cycle burst start, aligned with word 0.
- data_len  out  LEN_W  words in current burst.
- busy  out  1  burst in progress or awaiting cail_done.
- ovf_flag  out  1  sticky overrun indicator.
- drop_cnt  out  LEN_W  dropped-frame count, saturating.

Behaviour:
- Reset values: all outputs 0; both banks empty; fill bank = 0; FSM = IDLE; write pointer = 0.
- Fill side:
  - Each ad_data_vld writes ad_data to fill bank[wptr]; wptr increments.
  - Words beyond DEPTH in one frame are discarded; ovf_flag is set. The frame is still released with length DEPTH.
  - On ad_data_vld & ad_frame_end: the bank is marked full with len = wptr+1 (capped at DEPTH), and wptr returns to 0.
  - Fill then moves to the other bank if that bank is empty.
  - If the other bank is not empty (streaming or full-waiting), the next frame is dropped entirely:
    - its words are not written;
    - on its frame_end, drop_cnt increments (saturating at all-ones) and ovf_flag is set;
    - fill retries the switch at each subsequent frame start.
- FSM states IDLE, LOAD, STREAM, WAIT_DONE:
  - IDLE: if any bank is full, select the oldest full bank and go to LOAD. busy = 0.
  - LOAD: one cycle. Set read pointer = 0; latch data_len = bank len. busy = 1.
  - STREAM: short_data = bank[rptr], registered. cail_en = 1 only in the cycle showing word 0. rptr increments each cycle; after word len-1, go to WAIT_DONE.
  - WAIT_DONE: short_data holds the last word. On cail_done, mark the bank empty and go to IDLE.
- Latency: frame_end sampled at edge N with the feeder IDLE and no other bank full → LOAD at N+1 → cail_en high after edge N+2.
- Burst shape: exactly data_len consecutive cycles with valid words, starting in the cail_en cycle. No gaps.
- data_len is stable from LOAD until leaving WAIT_DONE. It is not cleared in IDLE.
- Simultaneous events:
  - cail_done with a frame_end in the same cycle: both are honoured. The freed bank may become the fill bank on the next cycle; the new full bank starts LOAD the next cycle.
  - cail_done outside WAIT_DONE is ignored.
  - clr_ovf with a drop event in the same cycle: clear wins, then count = 1 and flag = 1 from the drop (drop is applied after clear).
- Bank ordering: frames are emitted strictly in arrival order.
- Reset mid-burst: everything returns to reset values immediately. Partial frames are discarded. cail_en is never re-issued for a discarded frame.

Test Plan:
- Single frame: 8 words 1..8 with frame_end on word 8 → cail_en pulse 2 cycles after frame_end; short_data 1,2,...,8 on 8 consecutive cycles; data_len = 8; busy = 1 until cail_done.
- Short frame: 3 words 0x0010,0x0020,0x0030 → data_len = 3; 3-cycle burst; short_data then holds 0x0030.
- Back-to-back: frame A (1..8) with cail_done withheld, then frame B (9..16) → B buffered. cail_done for A → B burst with cail_en 2 cycles after the done edge; drop_cnt = 0.
- Overrun: third frame arrives while A is streaming and B is waiting → third frame dropped; ovf_flag = 1; drop_cnt = 1. clr_ovf → both 0.
- Over-length: 10 words before frame_end with DEPTH = 8 → data_len = 8; words 1..8 emitted; ovf_flag = 1.
- Reset during STREAM at word 4 → outputs 0 at once. After reset, a new frame 0xAAAA.. produces a normal burst starting with 0xAAAA.
